hwpe_stream_protocol_checker: RTL and testbench

HWPE_STREAM_PROTOCOL_CHECKER -- requirements
Module: hwpe_stream_protocol_checker

---
 rtl/hwpe_stream_protocol_checker.sv | 156 +++++++++++++++
 tb/tb_hwpe_stream_protocol_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hwpe_stream_protocol_checker.sv
// rtl/hwpe_stream_protocol_checker.sv - stream value-change/valid-deassert and TCDM r_valid timing checker; HWPE_STREAM_CHECKER_HS_CNT_EN adds per-channel handshake counters
module hwpe_stream_protocol_checker #(
  parameter int DATA_WIDTH   = 32,
  parameter int NB_CHAN      = 2,
  parameter int CNT_WIDTH    = 16,
  parameter int TCDM_LATENCY = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              enable_i,
  input  logic                              clear_i,
  input  logic [NB_CHAN-1:0]                valid_i,
  input  logic [NB_CHAN-1:0]                ready_i,
  input  logic [NB_CHAN*DATA_WIDTH-1:0]     data_i,
  input  logic [NB_CHAN*DATA_WIDTH/8-1:0]   strb_i,
  input  logic                              tcdm_req_i,
  input  logic                              tcdm_gnt_i,
  input  logic                              tcdm_wen_i,
  input  logic                              tcdm_r_valid_i,
  output logic [NB_CHAN-1:0]                vcr_err_o,
  output logic [NB_CHAN-1:0]                vdr_err_o,
  output logic                              trvr_err_o,
  output logic                              any_err_o,
  output logic [CNT_WIDTH-1:0]              err_cnt_o,
  output logic [NB_CHAN*CNT_WIDTH-1:0]      hs_cnt_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // Holds the worst case of 2*NB_CHAN+1 events in one cycle.
  localparam int EV_WIDTH   = $clog2(2 * NB_CHAN + 2);
  localparam int SUM_WIDTH  = ((CNT_WIDTH > EV_WIDTH) ? CNT_WIDTH : EV_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Refuse to elaborate with an illegal configuration rather than check nonsense.
  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || NB_CHAN < 1 || NB_CHAN > 16 ||
      TCDM_LATENCY < 1 || TCDM_LATENCY > 8 || CNT_WIDTH < 1) begin : g_param_err
    $error("hwpe_stream_protocol_checker: illegal parameter combination");
  end

  logic [NB_CHAN-1:0]            hist_valid_q;
  logic [NB_CHAN-1:0]            hist_ready_q;
  logic [NB_CHAN*DATA_WIDTH-1:0] hist_data_q;
  logic [NB_CHAN*STRB_WIDTH-1:0] hist_strb_q;
  logic                          armed_q;
  logic [TCDM_LATENCY-1:0]       rd_pipe_q;

  logic [NB_CHAN-1:0]            vcr_q;
  logic [NB_CHAN-1:0]            vdr_q;
  logic                          trvr_q;
  logic [CNT_WIDTH-1:0]          err_cnt_q;

  logic [NB_CHAN-1:0]            stalled;
  logic [NB_CHAN-1:0]            vcr_ev;
  logic [NB_CHAN-1:0]            vdr_ev;
  logic                          trvr_ev;
  logic                          rd_hs;
  logic [EV_WIDTH-1:0]           ev_cnt;
  logic [SUM_WIDTH-1:0]          err_sum;
  logic [CNT_WIDTH-1:0]          err_next;

  // A channel is stalled when last cycle offered valid data that was not taken.
  for (genvar k = 0; k < NB_CHAN; k++) begin : g_chan
    assign stalled[k] = armed_q & hist_valid_q[k] & ~hist_ready_q[k];
    assign vcr_ev[k]  = enable_i & stalled[k] &
                        ((data_i[k*DATA_WIDTH +: DATA_WIDTH] != hist_data_q[k*DATA_WIDTH +: DATA_WIDTH]) |
                         (strb_i[k*STRB_WIDTH +: STRB_WIDTH] != hist_strb_q[k*STRB_WIDTH +: STRB_WIDTH]));
    assign vdr_ev[k]  = enable_i & stalled[k] & ~valid_i[k];
  end

  assign rd_hs   = tcdm_req_i & tcdm_gnt_i & tcdm_wen_i;
  // Missing and spurious r_valid both reduce to a mismatch against the delayed grant.
  assign trvr_ev = enable_i & armed_q & (rd_pipe_q[TCDM_LATENCY-1] ^ tcdm_r_valid_i);

  // Number of violation events in the current cycle.
  always_comb begin
    ev_cnt = EV_WIDTH'(trvr_ev);
    for (int k = 0; k < NB_CHAN; k++) begin
      ev_cnt = ev_cnt + EV_WIDTH'(vcr_ev[k]) + EV_WIDTH'(vdr_ev[k]);
    end
  end

  assign err_sum  = SUM_WIDTH'(err_cnt_q) + SUM_WIDTH'(ev_cnt);
  assign err_next = (err_sum > SUM_WIDTH'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_WIDTH-1:0];

  // History, arming, TCDM read pipeline, sticky flags and saturating violation counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_valid_q <= '0;
      hist_ready_q <= '0;
      hist_data_q  <= '0;
      hist_strb_q  <= '0;
      armed_q      <= 1'b0;
      rd_pipe_q    <= '0;
      vcr_q        <= '0;
      vdr_q        <= '0;
      trvr_q       <= 1'b0;
      err_cnt_q    <= '0;
    end else if (clear_i) begin
      hist_valid_q <= '0;
      hist_ready_q <= '0;
      hist_data_q  <= '0;
      hist_strb_q  <= '0;
      armed_q      <= 1'b0;
      rd_pipe_q    <= '0;
      vcr_q        <= '0;
      vdr_q        <= '0;
      trvr_q       <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      hist_valid_q <= valid_i;
      hist_ready_q <= ready_i;
      hist_data_q  <= data_i;
      hist_strb_q  <= strb_i;
      armed_q      <= 1'b1;
      rd_pipe_q[0] <= rd_hs;
      for (int i = 1; i < TCDM_LATENCY; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
      vcr_q        <= vcr_q | vcr_ev;
      vdr_q        <= vdr_q | vdr_ev;
      trvr_q       <= trvr_q | trvr_ev;
      err_cnt_q    <= err_next;
    end
  end

  assign vcr_err_o  = vcr_q;
  assign vdr_err_o  = vdr_q;
  assign trvr_err_o = trvr_q;
  assign any_err_o  = (|vcr_q) | (|vdr_q) | trvr_q;
  assign err_cnt_o  = err_cnt_q;

`ifdef HWPE_STREAM_CHECKER_HS_CNT_EN
  logic [NB_CHAN*CNT_WIDTH-1:0] hs_cnt_q;

  // Per-channel saturating count of valid&ready handshakes while enabled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hs_cnt_q <= '0;
    end else if (clear_i) begin
      hs_cnt_q <= '0;
    end else begin
      for (int k = 0; k < NB_CHAN; k++) begin
        if (enable_i && valid_i[k] && ready_i[k] &&
            hs_cnt_q[k*CNT_WIDTH +: CNT_WIDTH] != CNT_MAX) begin
          hs_cnt_q[k*CNT_WIDTH +: CNT_WIDTH] <= hs_cnt_q[k*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
        end
      end
    end
  end

  assign hs_cnt_o = hs_cnt_q;
`else
  assign hs_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hwpe_stream_protocol_checker.sv
// tb/tb_hwpe_stream_protocol_checker.sv - table-driven bench for hwpe_stream_protocol_checker
module tb_hwpe_stream_protocol_checker;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [1:0]  valid;
  logic [1:0]  ready;
  logic [63:0] data;
  logic [7:0]  strb;
  logic        tcdm_req;
  logic        tcdm_gnt;
  logic        tcdm_wen;
  logic        tcdm_r_valid;
  logic [1:0]  vcr_err;
  logic [1:0]  vdr_err;
  logic        trvr_err;
  logic        any_err;
  logic [3:0]  err_cnt;
  logic [7:0]  hs_cnt;

  int checks;
  int failures;

  hwpe_stream_protocol_checker #(
    .DATA_WIDTH  (32),
    .NB_CHAN     (2),
    .CNT_WIDTH   (4),
    .TCDM_LATENCY(2)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .enable_i      (enable),
    .clear_i       (clear),
    .valid_i       (valid),
    .ready_i       (ready),
    .data_i        (data),
    .strb_i        (strb),
    .tcdm_req_i    (tcdm_req),
    .tcdm_gnt_i    (tcdm_gnt),
    .tcdm_wen_i    (tcdm_wen),
    .tcdm_r_valid_i(tcdm_r_valid),
    .vcr_err_o     (vcr_err),
    .vdr_err_o     (vdr_err),
    .trvr_err_o    (trvr_err),
    .any_err_o     (any_err),
    .err_cnt_o     (err_cnt),
    .hs_cnt_o      (hs_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        clr;
    logic [1:0]  v;
    logic [1:0]  r;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [7:0]  strb;
    logic        rd;
    logic        rv;
    logic [1:0]  e_vcr;
    logic [1:0]  e_vdr;
    logic        e_trvr;
    logic [3:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, input logic clr, input logic [1:0] v, input logic [1:0] r,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [7:0] s,
                              input logic rd, input logic rv, input logic [1:0] e_vcr,
                              input logic [1:0] e_vdr, input logic e_trvr, input logic [3:0] e_cnt);
    vec_t t;
    t.en = en; t.clr = clr; t.v = v; t.r = r; t.d0 = d0; t.d1 = d1; t.strb = s;
    t.rd = rd; t.rv = rv; t.e_vcr = e_vcr; t.e_vdr = e_vdr; t.e_trvr = e_trvr; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h expected=%0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    enable       = t.en;
    clear        = t.clr;
    valid        = t.v;
    ready        = t.r;
    data         = {t.d1, t.d0};
    strb         = t.strb;
    tcdm_req     = t.rd;
    tcdm_gnt     = t.rd;
    tcdm_wen     = t.rd;
    tcdm_r_valid = t.rv;
  endtask

  task automatic check_all(input int row, input logic [1:0] e_vcr, input logic [1:0] e_vdr,
                           input logic e_trvr, input logic [3:0] e_cnt);
    check("vcr_err", row, 32'(vcr_err), 32'(e_vcr));
    check("vdr_err", row, 32'(vdr_err), 32'(e_vdr));
    check("trvr_err", row, 32'(trvr_err), 32'(e_trvr));
    check("any_err", row, 32'(any_err), 32'((|e_vcr) | (|e_vdr) | e_trvr));
    check("err_cnt", row, 32'(err_cnt), 32'(e_cnt));
  endtask

  initial begin
    vec_t t;
    logic [3:0] exp_hs1;
    checks   = 0;
    failures = 0;

    // en clr v r d0 d1 strb rd rv | vcr vdr trvr cnt
    // VCR on channel 0
    vecs.push_back(mk(1, 0, 2'b01, 2'b00, 32'hA5A5A5A5, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 0, 2'b01, 2'b00, 32'h5A5A5A5A, 0, 8'hFF, 0, 0, 2'b01, 2'b00, 0, 1));
    vecs.push_back(mk(1, 0, 2'b01, 2'b01, 32'h5A5A5A5A, 0, 8'hFF, 0, 0, 2'b01, 2'b00, 0, 1));
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 0, 2'b01, 2'b00, 0, 1));
    vecs.push_back(mk(1, 1, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    // VDR on channel 1, then the same drop after a handshake
    vecs.push_back(mk(1, 0, 2'b10, 2'b00, 0, 1, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 1, 8'hFF, 0, 0, 2'b00, 2'b10, 0, 1));
    vecs.push_back(mk(1, 0, 2'b10, 2'b10, 0, 1, 8'hFF, 0, 0, 2'b00, 2'b10, 0, 1));
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 1, 8'hFF, 0, 0, 2'b00, 2'b10, 0, 1));
    vecs.push_back(mk(1, 1, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    // TRVR latency 2: on-time r_valid, then early r_valid (spurious + missing)
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 8'hFF, 1, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 1, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 8'hFF, 1, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 1, 2'b00, 2'b00, 1, 1));
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 1, 2));
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 1, 2));
    vecs.push_back(mk(1, 1, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    // clear wins over a simultaneous VCR; enable low masks violations
    vecs.push_back(mk(1, 0, 2'b01, 2'b00, 1, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 0, 2'b01, 2'b00, 2, 0, 8'hFF, 0, 0, 2'b01, 2'b00, 0, 1));
    vecs.push_back(mk(1, 1, 2'b01, 2'b00, 3, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 0, 2'b01, 2'b00, 3, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 2'b01, 2'b00, 4, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(0, 0, 2'b00, 2'b00, 4, 0, 8'hFF, 0, 1, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 0, 2'b00, 2'b00, 4, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    // strobe-only change is a VCR
    vecs.push_back(mk(1, 0, 2'b01, 2'b00, 7, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 0, 2'b01, 2'b00, 7, 0, 8'hFE, 0, 0, 2'b01, 2'b00, 0, 1));
    vecs.push_back(mk(1, 1, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    // three events per cycle for six cycles saturates the 4-bit counter
    vecs.push_back(mk(1, 0, 2'b11, 2'b00, 10, 20, 8'hFF, 0, 0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(mk(1, 0, 2'b11, 2'b00, 11, 21, 8'hFF, 0, 1, 2'b11, 2'b00, 1, 3));
    vecs.push_back(mk(1, 0, 2'b11, 2'b00, 12, 22, 8'hFF, 0, 1, 2'b11, 2'b00, 1, 6));
    vecs.push_back(mk(1, 0, 2'b11, 2'b00, 13, 23, 8'hFF, 0, 1, 2'b11, 2'b00, 1, 9));
    vecs.push_back(mk(1, 0, 2'b11, 2'b00, 14, 24, 8'hFF, 0, 1, 2'b11, 2'b00, 1, 12));
    vecs.push_back(mk(1, 0, 2'b11, 2'b00, 15, 25, 8'hFF, 0, 1, 2'b11, 2'b00, 1, 15));
    vecs.push_back(mk(1, 0, 2'b11, 2'b00, 16, 26, 8'hFF, 0, 1, 2'b11, 2'b00, 1, 15));

    // reset state
    rst_n = 1'b0;
    drive(mk(1, 0, 0, 0, 0, 0, 8'hFF, 0, 0, 0, 0, 0, 0));
    #12;
    check_all(-1, 2'b00, 2'b00, 0, 0);
    check("hs_cnt", -1, 32'(hs_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      @(negedge clk);
      drive(t);
      @(posedge clk);
      #1;
      check_all(i, t.e_vcr, t.e_vdr, t.e_trvr, t.e_cnt);
    end

    // asynchronous reset between edges with flags set
    #3;
    rst_n = 1'b0;
    #1;
    check_all(100, 2'b00, 2'b00, 0, 0);
    check("hs_cnt", 100, 32'(hs_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1, 0, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_all(101, 2'b00, 2'b00, 0, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    check_all(102, 2'b00, 2'b00, 1, 1);

    // handshake counter: 10 enabled handshakes on channel 1, one masked
    @(negedge clk);
    drive(mk(1, 1, 2'b00, 2'b00, 0, 0, 8'hFF, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_all(103, 2'b00, 2'b00, 0, 0);
    check("hs_cnt", 103, 32'(hs_cnt), 32'h0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(mk((i == 5) ? 1'b0 : 1'b1, 0, 2'b10, 2'b10, 0, 32'(i), 8'hFF, 0, 0, 0, 0, 0, 0));
      @(posedge clk);
    end
    #1;
`ifdef HWPE_STREAM_CHECKER_HS_CNT_EN
    exp_hs1 = 4'd10;
`else
    exp_hs1 = 4'd0;
`endif
    check("hs_cnt_ch1", 104, 32'(hs_cnt[7:4]), 32'(exp_hs1));
    check("hs_cnt_ch0", 104, 32'(hs_cnt[3:0]), 32'h0);
    check_all(104, 2'b00, 2'b00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
